// File: rtl/lanectrl_delay_line_sequencer_if.sv
// ============================================================================
// Module  : lanectrl_delay_line_sequencer_if
// Brief   : Command/response and LANECTRL delay-line signal bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface lanectrl_delay_line_sequencer_if;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [1:0] CMD_OP;
   logic       CMD_SEL;
   logic       CMD_DIR;
   logic [7:0] CMD_COUNT;
   logic       DONE;
   logic       OOR;
   logic       ERR;
   logic [7:0] TAPS_DONE;
   logic       RX_DELAY_LINE_OUT_OF_RANGE;
   logic       TX_DELAY_LINE_OUT_OF_RANGE;
   logic       DELAY_LINE_SEL;
   logic       DELAY_LINE_DIRECTION;
   logic       DELAY_LINE_LOAD;
   logic       DELAY_LINE_MOVE;
   logic       HS_IO_CLK_PAUSE;

   // Master is the training engine plus the LANECTRL status side.
   modport master (
      output CMD_VALID, CMD_OP, CMD_SEL, CMD_DIR, CMD_COUNT,
      output RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE,
      input  CMD_READY, DONE, OOR, ERR, TAPS_DONE,
      input  DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD,
      input  DELAY_LINE_MOVE, HS_IO_CLK_PAUSE
   );

   modport slave (
      input  CMD_VALID, CMD_OP, CMD_SEL, CMD_DIR, CMD_COUNT,
      input  RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE,
      output CMD_READY, DONE, OOR, ERR, TAPS_DONE,
      output DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD,
      output DELAY_LINE_MOVE, HS_IO_CLK_PAUSE
   );
endinterface

`default_nettype wire

// File: rtl/lanectrl_delay_line_sequencer.sv
// ============================================================================
// Module  : lanectrl_delay_line_sequencer
// Brief   : Turns step/load/pause commands into spaced LANECTRL delay-line pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lanectrl_delay_line_sequencer #(
   parameter int MOVE_GAP     = 2,
   parameter int PAUSE_CYCLES = 4
) (
   input  wire logic                     FAB_CLK,
   input  wire logic                     RESET,
   lanectrl_delay_line_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_MOVE, S_GAP, S_PAUSE_PRE, S_LOAD, S_PAUSE_POST, S_FINISH
   } state_t;

   localparam logic [1:0] c_OP_STEP  = 2'b00;
   localparam logic [1:0] c_OP_LOAD  = 2'b01;
   localparam logic [1:0] c_OP_PAUSE = 2'b10;
   localparam logic [3:0] c_GAP_M1   = 4'(MOVE_GAP - 1);
   localparam logic [3:0] c_PAUSE_M1 = 4'(PAUSE_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic [7:0] r_taps;
   logic [7:0] w_taps_nxt;
   logic       w_accept;
   logic       w_oor_hit;
   logic       w_oor_sel;

   logic [1:0] r_op;
   logic [7:0] r_count;
   logic       r_sel;
   logic       r_dir;
   logic       r_ready;
   logic       r_done;
   logic       r_oor;
   logic       r_err;
   logic [7:0] r_taps_done;
   logic       r_move;
   logic       r_load;
   logic       r_pause;

   assign w_oor_sel = r_sel ? bus.TX_DELAY_LINE_OUT_OF_RANGE
                            : bus.RX_DELAY_LINE_OUT_OF_RANGE;

   always_ff @(posedge FAB_CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_taps  <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_taps  <= w_taps_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_taps_nxt  = r_taps;
      w_accept    = 1'b0;
      w_oor_hit   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.CMD_VALID) begin
               w_accept    = 1'b1;
               w_taps_nxt  = 8'd0;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            if (r_op == c_OP_STEP) begin
               w_state_nxt = (r_count == 8'd0) ? S_FINISH : S_MOVE;
            end else if (r_op == c_OP_LOAD || r_op == c_OP_PAUSE) begin
               w_state_nxt = S_PAUSE_PRE;
               w_cnt_nxt   = c_PAUSE_M1;
            end else begin
               w_state_nxt = S_FINISH;
            end
         end
         S_MOVE: begin
            w_taps_nxt  = r_taps + 8'd1;
            w_cnt_nxt   = c_GAP_M1;
            w_state_nxt = S_GAP;
         end
         S_GAP: begin
            // Out-of-range is only trusted once the line has settled for the full gap.
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else if (w_oor_sel) begin
               w_oor_hit   = 1'b1;
               w_state_nxt = S_FINISH;
            end else if (r_taps == r_count) begin
               w_state_nxt = S_FINISH;
            end else begin
               w_state_nxt = S_MOVE;
            end
         end
         S_PAUSE_PRE: begin
            if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
            else               w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_cnt_nxt   = c_PAUSE_M1;
            w_state_nxt = S_PAUSE_POST;
         end
         S_PAUSE_POST: begin
            if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
            else               w_state_nxt = S_FINISH;
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each pulse lines up with its state.
   always_ff @(posedge FAB_CLK or posedge RESET) begin
      if (RESET) begin
         r_op        <= 2'b00;
         r_count     <= 8'd0;
         r_sel       <= 1'b0;
         r_dir       <= 1'b0;
         r_ready     <= 1'b1;
         r_done      <= 1'b0;
         r_oor       <= 1'b0;
         r_err       <= 1'b0;
         r_taps_done <= 8'd0;
         r_move      <= 1'b0;
         r_load      <= 1'b0;
         r_pause     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op        <= bus.CMD_OP;
            r_count     <= bus.CMD_COUNT;
            r_sel       <= bus.CMD_SEL;
            r_dir       <= bus.CMD_DIR;
            r_oor       <= 1'b0;
            r_err       <= 1'b0;
            r_taps_done <= 8'd0;
         end else begin
            if (w_oor_hit) r_oor <= 1'b1;
            if (r_state == S_SETUP && r_op == 2'b11) r_err <= 1'b1;
            if (w_state_nxt == S_FINISH) r_taps_done <= w_taps_nxt;
         end
         r_ready <= (w_state_nxt == S_IDLE);
         r_done  <= (w_state_nxt == S_FINISH);
         r_move  <= (w_state_nxt == S_MOVE);
         r_load  <= (w_state_nxt == S_LOAD) && (r_op == c_OP_LOAD);
         r_pause <= (w_state_nxt == S_PAUSE_PRE) || (w_state_nxt == S_LOAD) ||
                    (w_state_nxt == S_PAUSE_POST);
      end
   end

   assign bus.CMD_READY            = r_ready;
   assign bus.DONE                 = r_done;
   assign bus.OOR                  = r_oor;
   assign bus.ERR                  = r_err;
   assign bus.TAPS_DONE            = r_taps_done;
   assign bus.DELAY_LINE_SEL       = r_sel;
   assign bus.DELAY_LINE_DIRECTION = r_dir;
   assign bus.DELAY_LINE_LOAD      = r_load;
   assign bus.DELAY_LINE_MOVE      = r_move;
   assign bus.HS_IO_CLK_PAUSE      = r_pause;

endmodule

`default_nettype wire

// File: tb/tb_lanectrl_delay_line_sequencer.sv
// ============================================================================
// Module  : tb_lanectrl_delay_line_sequencer
// Brief   : Directed, table-driven bench for the delay-line sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lanectrl_delay_line_sequencer;

   localparam int G    = 2;
   localparam int P    = 4;
   localparam int MAXC = 1000;

   logic clk;
   logic rst;

   lanectrl_delay_line_sequencer_if u_if ();

   lanectrl_delay_line_sequencer #(.MOVE_GAP(G), .PAUSE_CYCLES(P)) u_dut (
      .FAB_CLK (clk),
      .RESET   (rst),
      .bus     (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int op, sel, dir, count;
      int oor_tap;     // tap after which the selected OOR input rises (0 = never)
      int rx_toggle;   // toggle RX OOR every cycle
      int exp_done, exp_taps, exp_oor, exp_err, exp_moves;
      int exp_pfirst, exp_plast, exp_pcount, exp_loads, exp_load_cyc;
   } vec_t;

   vec_t tbl [8];
   int   checks;
   int   errors;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic issue(input int op, input int sel, input int dir, input int count);
      int b;
      @(negedge clk);
      u_if.CMD_OP    = 2'(op);
      u_if.CMD_SEL   = sel[0];
      u_if.CMD_DIR   = dir[0];
      u_if.CMD_COUNT = 8'(count);
      u_if.CMD_VALID = 1'b1;
      b = 0;
      while (!u_if.CMD_READY && b < 100) begin
         @(negedge clk);
         b++;
      end
      if (b == 100) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      u_if.CMD_VALID = 1'b0;
   endtask

   task automatic run_cmd(input string nm, input vec_t v);
      int cyc, moves, mpos_bad, loads, load_cyc, pfirst, plast, pcnt, both, stab_bad;
      int done_cyc, taps, oor, err, pstep;
      cyc = 1; moves = 0; mpos_bad = 0; loads = 0; load_cyc = 0;
      pfirst = 0; plast = 0; pcnt = 0; both = 0; stab_bad = 0;
      done_cyc = 0; taps = -1; oor = -1; err = -1; pstep = 0;
      issue(v.op, v.sel, v.dir, v.count);
      while (cyc <= MAXC) begin
         if (u_if.DELAY_LINE_MOVE) begin
            if (cyc != 2 + moves * (1 + G)) mpos_bad++;
            moves++;
            if (v.oor_tap != 0 && moves == v.oor_tap) begin
               if (v.sel != 0) u_if.TX_DELAY_LINE_OUT_OF_RANGE = 1'b1;
               else            u_if.RX_DELAY_LINE_OUT_OF_RANGE = 1'b1;
            end
         end
         if (u_if.DELAY_LINE_LOAD) begin
            loads++;
            load_cyc = cyc;
         end
         if (u_if.HS_IO_CLK_PAUSE) begin
            if (pfirst == 0) pfirst = cyc;
            plast = cyc;
            pcnt++;
            if (v.op == 0) pstep++;
         end
         if (u_if.DELAY_LINE_MOVE && u_if.DELAY_LINE_LOAD) both++;
         if (u_if.DELAY_LINE_SEL != v.sel[0] || u_if.DELAY_LINE_DIRECTION != v.dir[0])
            stab_bad++;
         if (v.rx_toggle != 0)
            u_if.RX_DELAY_LINE_OUT_OF_RANGE = ~u_if.RX_DELAY_LINE_OUT_OF_RANGE;
         if (u_if.DONE) begin
            done_cyc = cyc;
            taps     = int'(u_if.TAPS_DONE);
            oor      = int'(u_if.OOR);
            err      = int'(u_if.ERR);
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({nm, "_done_cyc"}, done_cyc, v.exp_done);
      chk({nm, "_taps"}, taps, v.exp_taps);
      chk({nm, "_oor"}, oor, v.exp_oor);
      chk({nm, "_err"}, err, v.exp_err);
      chk({nm, "_moves"}, moves, v.exp_moves);
      chk({nm, "_move_pos"}, mpos_bad, 0);
      chk({nm, "_pause_first"}, pfirst, v.exp_pfirst);
      chk({nm, "_pause_last"}, plast, v.exp_plast);
      chk({nm, "_pause_count"}, pcnt, v.exp_pcount);
      chk({nm, "_pause_in_step"}, pstep, 0);
      chk({nm, "_loads"}, loads, v.exp_loads);
      chk({nm, "_load_cyc"}, load_cyc, v.exp_load_cyc);
      chk({nm, "_move_load_overlap"}, both, 0);
      chk({nm, "_sel_dir_stable"}, stab_bad, 0);
      @(posedge clk);
      #1;
      chk({nm, "_done_one_cycle"}, int'(u_if.DONE), 0);
      chk({nm, "_ready_after"}, int'(u_if.CMD_READY), 1);
      chk({nm, "_taps_hold"}, int'(u_if.TAPS_DONE), v.exp_taps);
      u_if.RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
      u_if.TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
   endtask

   initial begin
      int dones, first_done, second_done;
      checks = 0;
      errors = 0;
      //          op sel dir cnt  ot rx  done taps oor err mv  pf pl pc ld lc
      tbl[0] = '{0, 0, 1, 3,   0, 0,  11,  3,   0,  0,  3,  0, 0, 0, 0, 0};
      tbl[1] = '{0, 1, 0, 10,  4, 1,  14,  4,   1,  0,  4,  0, 0, 0, 0, 0};
      tbl[2] = '{1, 0, 0, 0,   0, 0,  11,  0,   0,  0,  0,  2, 10, 9, 1, 6};
      tbl[3] = '{2, 1, 1, 0,   0, 0,  11,  0,   0,  0,  0,  2, 10, 9, 0, 0};
      tbl[4] = '{3, 0, 1, 5,   0, 0,  2,   0,   0,  1,  0,  0, 0, 0, 0, 0};
      tbl[5] = '{0, 1, 1, 0,   0, 0,  2,   0,   0,  0,  0,  0, 0, 0, 0, 0};
      tbl[6] = '{0, 0, 0, 1,   1, 0,  5,   1,   1,  0,  1,  0, 0, 0, 0, 0};
      tbl[7] = '{0, 1, 1, 255, 0, 0,  767, 255, 0,  0,  255, 0, 0, 0, 0, 0};

      rst = 1'b1;
      u_if.CMD_VALID = 1'b0;
      u_if.CMD_OP = 2'b00;
      u_if.CMD_SEL = 1'b0;
      u_if.CMD_DIR = 1'b0;
      u_if.CMD_COUNT = 8'd0;
      u_if.RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
      u_if.TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
      #12;
      chk("rst_ready", int'(u_if.CMD_READY), 1);
      chk("rst_done", int'(u_if.DONE), 0);
      chk("rst_pause", int'(u_if.HS_IO_CLK_PAUSE), 0);
      chk("rst_move", int'(u_if.DELAY_LINE_MOVE), 0);
      chk("rst_taps", int'(u_if.TAPS_DONE), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_cmd($sformatf("vec%0d", i), tbl[i]);

      // Back-to-back zero-count steps with CMD_VALID held high.
      @(negedge clk);
      u_if.CMD_OP = 2'b00;
      u_if.CMD_COUNT = 8'd0;
      u_if.CMD_VALID = 1'b1;
      @(posedge clk);
      #1;
      dones = 0; first_done = 0; second_done = 0;
      for (int c = 1; c <= 8; c++) begin
         if (u_if.DONE) begin
            dones++;
            if (first_done == 0) first_done = c;
            else                 second_done = c;
         end
         if (c == 3) chk("b2b_ready_c3", int'(u_if.CMD_READY), 1);
         if (c == 4) chk("b2b_ready_c4", int'(u_if.CMD_READY), 0);
         if (c == 5) u_if.CMD_VALID = 1'b0;
         @(posedge clk);
         #1;
      end
      chk("b2b_dones", dones, 2);
      chk("b2b_first", first_done, 2);
      chk("b2b_second", second_done, 5);

      // Reset during a load: pause drops at once, no DONE afterwards.
      issue(1, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rstmid_pause_before", int'(u_if.HS_IO_CLK_PAUSE), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_pause_async", int'(u_if.HS_IO_CLK_PAUSE), 0);
      chk("rstmid_ready_async", int'(u_if.CMD_READY), 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk);
         #1;
         if (u_if.DONE) dones++;
      end
      chk("rstmid_no_done", dones, 0);
      run_cmd("post_rst", '{0, 1, 0, 2, 0, 0, 8, 2, 0, 0, 2, 0, 0, 0, 0, 0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
